div: RTL and testbench

Sequential signed 32-bit integer divider, the counterpart to the Booth multiplier in the processor's multdiv unit. Accepts a dividend/divisor pair on a one-cycle start pulse, produces the truncated quotient after a fixed 33-cycle latency, and flags divide-by-zero. The multdiv wrapper arbitrates between this block and the multiplier and forwards `data_result`, `data_exception` and `data_resultRDY` to the pipeline stall logic.

---
 rtl/div_pkg.sv | 21 ++
 rtl/adder32.sv | 27 ++
 rtl/div_step.sv | 39 +++
 rtl/div.sv | 137 +++++++++++++
 tb/tb_div.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the multdiv unit: divider FSM encoding and iteration
// count, plus the multiplier ready count so the wrapper has one source for both.
package div_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_t;

    localparam int DIV_ITERS    = 32;
    localparam int DIV_CNT_W    = 6;
    localparam int DATA_W       = 32;

    // Cycles from start to ready for the radix-4 Booth multiplier.
    localparam int MULT_RDY_CNT = 16;

    localparam logic [DIV_CNT_W-1:0] DIV_LAST_ITER = DIV_CNT_W'(DIV_ITERS - 1);

endpackage

// File: rtl/adder32.sv
// 32-bit ripple adder shared across the ALU and multdiv unit; flags assume the
// caller is forming x - y as x + ~y + 1.
module adder32 (
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        Cin,
    output logic [31:0] Sum,
    output logic        isNotEqual,
    output logic        isLessThan,
    output logic        overflow
);

    logic [32:0] carry;

    always_comb begin
        carry[0] = Cin;
        for (int i = 0; i < 32; i++) begin
            Sum[i]       = x[i] ^ y[i] ^ carry[i];
            carry[i + 1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
        end
    end

    assign overflow   = carry[32] ^ carry[31];
    assign isNotEqual = |Sum;
    assign isLessThan = Sum[31] ^ overflow;

endmodule

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract |B|, keep or restore.
module div_step (
    input  logic [32:0] rem,
    input  logic        next_bit,
    input  logic [31:0] mag_b,
    output logic [32:0] rem_next,
    output logic        q_bit
);

    logic [32:0] shifted;
    logic [31:0] diff;
    logic        ovf;
    logic        carry_31;
    logic        carry_out;
    logic        unused_ne;
    logic        unused_lt;

    assign shifted = {rem[31:0], next_bit};

    adder32 u_sub (
        .x          (shifted[31:0]),
        .y          (~mag_b),
        .Cin        (1'b1),
        .Sum        (diff),
        .isNotEqual (unused_ne),
        .isLessThan (unused_lt),
        .overflow   (ovf)
    );

    // adder32 exposes no carry-out; recover it from the bit-31 carry and overflow.
    assign carry_31  = diff[31] ^ shifted[31] ^ ~mag_b[31];
    assign carry_out = ovf ^ carry_31;

    // A set bit above 32 means the shifted remainder already exceeds any divisor.
    assign q_bit    = rem[32] | shifted[32] | carry_out;
    assign rem_next = q_bit ? {1'b0, diff} : shifted;

endmodule

// File: rtl/div.sv
// Sequential signed 32-bit restoring divider: start pulse, 33-cycle latency,
// truncated quotient with a divide-by-zero flag.
module div
    import div_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);

    div_state_t           state_q, state_d;
    logic [32:0]          rem_q;
    logic [31:0]          quo_q;
    logic [31:0]          mag_b_q;
    logic                 sign_q;
    logic                 dbz_q;
    logic [DIV_CNT_W-1:0] count_q;

    logic [31:0] neg_a, neg_b, neg_q;
    logic [31:0] abs_a, abs_b, fixed_q;
    logic [32:0] rem_next;
    logic        q_bit;
    logic [2:0]  unused_ne, unused_lt, unused_ovf;

    adder32 u_neg_a (
        .x          (~data_operandA),
        .y          (32'd0),
        .Cin        (1'b1),
        .Sum        (neg_a),
        .isNotEqual (unused_ne[0]),
        .isLessThan (unused_lt[0]),
        .overflow   (unused_ovf[0])
    );

    adder32 u_neg_b (
        .x          (~data_operandB),
        .y          (32'd0),
        .Cin        (1'b1),
        .Sum        (neg_b),
        .isNotEqual (unused_ne[1]),
        .isLessThan (unused_lt[1]),
        .overflow   (unused_ovf[1])
    );

    adder32 u_neg_q (
        .x          (~quo_q),
        .y          (32'd0),
        .Cin        (1'b1),
        .Sum        (neg_q),
        .isNotEqual (unused_ne[2]),
        .isLessThan (unused_lt[2]),
        .overflow   (unused_ovf[2])
    );

    // -2^31 negates to itself, which is exactly its magnitude as unsigned.
    assign abs_a   = data_operandA[31] ? neg_a : data_operandA;
    assign abs_b   = data_operandB[31] ? neg_b : data_operandB;
    assign fixed_q = sign_q ? neg_q : quo_q;

    div_step u_step (
        .rem      (rem_q),
        .next_bit (quo_q[31]),
        .mag_b    (mag_b_q),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        if (ctrl_DIV) begin
            state_d = DIV_RUN;
        end else begin
            case (state_q)
                DIV_IDLE: state_d = DIV_IDLE;
                DIV_RUN:  if (count_q == DIV_LAST_ITER) state_d = DIV_FIX;
                DIV_FIX:  state_d = DIV_DONE;
                DIV_DONE: state_d = DIV_IDLE;
                default:  state_d = DIV_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= DIV_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The dividend is shifted out of quo_q's top while quotient bits enter at the bottom.
    always_ff @(posedge clock) begin
        if (reset) begin
            rem_q          <= '0;
            quo_q          <= '0;
            mag_b_q        <= '0;
            sign_q         <= 1'b0;
            dbz_q          <= 1'b0;
            count_q        <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (ctrl_DIV) begin
                rem_q   <= '0;
                quo_q   <= abs_a;
                mag_b_q <= abs_b;
                sign_q  <= data_operandA[31] ^ data_operandB[31];
                dbz_q   <= (data_operandB == 32'd0);
                count_q <= '0;
            end else begin
                case (state_q)
                    DIV_RUN: begin
                        rem_q   <= rem_next;
                        quo_q   <= {quo_q[30:0], q_bit};
                        count_q <= count_q + 1'b1;
                    end
                    DIV_FIX: begin
                        data_result    <= dbz_q ? 32'd0 : fixed_q;
                        data_exception <= dbz_q;
                        data_resultRDY <= 1'b1;
                        count_q        <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div.sv
// Directed bench for div: latency, signed quotients, divide-by-zero, overflow
// wrap, restart, and reset behaviour.
module tb_div;

    logic        clock;
    logic        reset;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int tests_run    = 0;
    int tests_failed = 0;

    div dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drives a start pulse onto the next rising edge, then scrambles the operands.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_DIV      = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Counts edges after the start edge until RDY is seen; 0 means it never came.
    task automatic wait_rdy(output int lat);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                lat = n;
                break;
            end
        end
    endtask

    // Advances n edges and counts how many of them showed RDY.
    task automatic quiet_cycles(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) pulses++;
        end
    endtask

    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_res, input logic exp_exc);
        int lat;
        start_op(a, b);
        wait_rdy(lat);
        check({tag, " latency"}, lat, 33);
        check({tag, " result"}, data_result, exp_res);
        check({tag, " exception"}, {31'd0, data_exception}, {31'd0, exp_exc});
        @(posedge clock);
        #1;
        check({tag, " rdy one cycle"}, {31'd0, data_resultRDY}, 32'd0);
    endtask

    initial begin
        int lat;
        int pulses;

        reset         = 1'b1;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset result", data_result, 32'd0);
        check("reset exception", {31'd0, data_exception}, 32'd0);
        check("reset rdy", {31'd0, data_resultRDY}, 32'd0);
        reset = 1'b0;

        run_div("100/7",   32'd100,        32'd7,          32'h0000000E, 1'b0);
        run_div("-100/7",  32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2, 1'b0);
        run_div("100/-7",  32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2, 1'b0);
        run_div("-100/-7", 32'hFFFFFF9C,   32'hFFFFFFF9,   32'h0000000E, 1'b0);
        run_div("5/7",     32'd5,          32'd7,          32'h00000000, 1'b0);
        run_div("7/0",     32'd7,          32'd0,          32'h00000000, 1'b1);
        run_div("9/3",     32'd9,          32'd3,          32'h00000003, 1'b0);
        run_div("min/-1",  32'h80000000,   32'hFFFFFFFF,   32'h80000000, 1'b0);
        run_div("min/1",   32'h80000000,   32'd1,          32'h80000000, 1'b0);
        run_div("big/neg", 32'h7FFFFFFF,   32'hFFFFFFFE,   32'hC0000001, 1'b0);

        // Restart at +10: only the second op completes.
        start_op(32'd100, 32'd7);
        quiet_cycles(9, pulses);
        start_op(32'd50, 32'd5);
        wait_rdy(lat);
        check("restart latency", lat, 33);
        check("restart early rdy", pulses, 0);
        check("restart result", data_result, 32'd10);
        quiet_cycles(40, pulses);
        check("restart single rdy", pulses, 0);

        // Restart on the FIX edge: no pulse, previous result held.
        start_op(32'd100, 32'd7);
        quiet_cycles(32, pulses);
        start_op(32'd63, 32'd9);
        check("fix restart no rdy", {31'd0, data_resultRDY}, 32'd0);
        check("fix restart held", data_result, 32'd10);
        wait_rdy(lat);
        check("fix restart latency", lat, 33);
        check("fix restart result", data_result, 32'd7);
        check("rdy before fix restart", pulses, 0);

        // Reset at +20 aborts.
        start_op(32'd100, 32'd7);
        quiet_cycles(19, pulses);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("abort result", data_result, 32'd0);
        check("abort exception", {31'd0, data_exception}, 32'd0);
        quiet_cycles(40, lat);
        check("abort no rdy", pulses + lat, 0);

        // Reset and start on the same edge: reset wins.
        run_div("pre 100/7", 32'd100, 32'd7, 32'h0000000E, 1'b0);
        @(negedge clock);
        reset         = 1'b1;
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd100;
        data_operandB = 32'd7;
        @(posedge clock);
        #1;
        reset    = 1'b0;
        ctrl_DIV = 1'b0;
        check("rst+start result", data_result, 32'd0);
        quiet_cycles(40, pulses);
        check("rst+start no rdy", pulses, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
